// File: rtl/pe_mult_seq.sv
// pe_mult_seq: LANES x int16 signed multiplier front end, MULS multipliers time-shared over LANES/MULS passes.
// Optional early finish when all remaining weight lanes are zero: define PE_MULT_ZERO_SKIP_EN.
module pe_mult_seq #(
  parameter int LANES = 32,
  parameter int DW    = 16,
  parameter int MULS  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DW-1:0]     neuron,
  input  logic [LANES*DW-1:0]     weight,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*2*DW-1:0]   mult_result
);

  localparam int PASSES = LANES / MULS;
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int PWID   = 2 * DW;

  if (LANES % MULS != 0) begin : g_bad_muls
    $error("pe_mult_seq: MULS must divide LANES");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_q;
  logic [PW-1:0]           pass_q;
  logic [LANES*DW-1:0]     nrn_q;
  logic [LANES*DW-1:0]     wgt_q;
  logic [LANES*PWID-1:0]   res_q;
  logic [LANES*PWID-1:0]   res_d;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    finish;

`ifdef PE_MULT_ZERO_SKIP_EN
  logic [PASSES-1:0]       grp_nz;
  logic                    rest_zero;

  // One nonzero flag per multiplier group; the remainder is zero when no flag at or above pass_q is set.
  always_comb begin
    grp_nz = '0;
    for (int p = 0; p < PASSES; p++) begin
      grp_nz[p] = |wgt_q[p*MULS*DW +: MULS*DW];
    end
    rest_zero = ((grp_nz >> pass_q) == '0);
  end

  assign finish = rest_zero || (pass_q == PW'(PASSES - 1));
`else
  assign finish = (pass_q == PW'(PASSES - 1));
`endif

  always_comb begin : p_mult
    logic [PWID-1:0] ax;
    logic [PWID-1:0] bx;
    int              lane;
    res_d = res_q;
    ax    = '0;
    bx    = '0;
    lane  = 0;
    for (int m = 0; m < MULS; m++) begin
      lane = int'(pass_q) * MULS + m;
      // Sign-extend both operands so the low 2*DW bits of the product are the exact signed result.
      ax = {{DW{nrn_q[lane*DW + DW - 1]}}, nrn_q[lane*DW +: DW]};
      bx = {{DW{wgt_q[lane*DW + DW - 1]}}, wgt_q[lane*DW +: DW]};
      res_d[lane*PWID +: PWID] = ax * bx;
    end
`ifdef PE_MULT_ZERO_SKIP_EN
    if (rest_zero) begin
      for (int l = 0; l < LANES; l++) begin
        if (l >= int'(pass_q) * MULS) res_d[l*PWID +: PWID] = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pass_q      <= '0;
      nrn_q       <= '0;
      wgt_q       <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            nrn_q      <= neuron;
            wgt_q      <= weight;
            pass_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          res_q <= res_d;
          if (finish) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            pass_q <= pass_q + PW'(1);
          end
        end
        DONE: begin
          // Operands are not re-sampled here: a new vector waits for IDLE.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign mult_result = res_q;

endmodule

// File: tb/tb_pe_mult_seq.sv
// tb_pe_mult_seq: scoreboard bench for pe_mult_seq; expected products and latency come from a lane-wise model.
// Honours PE_MULT_ZERO_SKIP_EN when it is defined for the whole build.
module tb_pe_mult_seq;
  localparam int LANES  = 32;
  localparam int DW     = 16;
  localparam int MULS   = 8;
  localparam int PASSES = LANES / MULS;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [LANES*DW-1:0]  neuron = '0;
  logic [LANES*DW-1:0]  weight = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [LANES*2*DW-1:0] mult_result;

  typedef struct {
    logic [LANES*2*DW-1:0] res;
    int                    e0;
    int                    lat;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   sent = 0;
  int   recvd = 0;
  int   lost = 0;
  bit   rand_ready = 1'b0;
  bit   ov_prev = 1'b0;

  pe_mult_seq #(.LANES(LANES), .DW(DW), .MULS(MULS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .neuron(neuron), .weight(weight), .out_valid(out_valid),
    .out_ready(out_ready), .mult_result(mult_result)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  function automatic logic [LANES*2*DW-1:0] ref_mult(input logic [LANES*DW-1:0] n, input logic [LANES*DW-1:0] w);
    logic [LANES*2*DW-1:0] r;
    logic signed [DW-1:0]  a;
    logic signed [DW-1:0]  b;
    int                    p;
    r = '0;
    for (int j = 0; j < LANES; j++) begin
      a = n[DW*j +: DW];
      b = w[DW*j +: DW];
      p = int'(a) * int'(b);
      r[2*DW*j +: 2*DW] = p;
    end
    return r;
  endfunction

  function automatic int ref_lat(input logic [LANES*DW-1:0] w);
`ifdef PE_MULT_ZERO_SKIP_EN
    int g;
    g = -1;
    for (int j = 0; j < LANES; j++) if (w[DW*j +: DW] != '0) g = j / MULS;
    return (g + 2 < PASSES) ? g + 2 : PASSES;
`else
    return (w === w) ? PASSES : PASSES;
`endif
  endfunction

  function automatic logic [LANES*DW-1:0] rand_vec();
    logic [LANES*DW-1:0] v;
    for (int k = 0; k < LANES*DW/32; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_vec(input string name, input logic [LANES*2*DW-1:0] act, input logic [LANES*2*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int j = 0; j < LANES; j++) begin
        if (act[2*DW*j +: 2*DW] !== exp[2*DW*j +: 2*DW]) begin
          $display("FAIL %s lane %0d got=%h expected=%h (cyc %0d)", name, j,
                   act[2*DW*j +: 2*DW], exp[2*DW*j +: 2*DW], cyc);
          break;
        end
      end
    end
  endtask

  // Monitor: every cycle a result is presented it must equal the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid got=1 expected=0 (cyc %0d)", cyc);
        end else begin
          if (!ov_prev) chk("latency", cyc - sbq[0].e0, sbq[0].lat);
          chk_vec("mult_result", mult_result, sbq[0].res);
          chk("in_ready_in_done", int'(in_ready), 0);
          if (out_ready) begin
            void'(sbq.pop_front());
            recvd++;
          end
        end
      end
      ov_prev = out_valid;
    end
  end

  // Called at posedge+1; waits for in_ready, then presents one vector for one cycle.
  task automatic send(input logic [LANES*DW-1:0] n, input logic [LANES*DW-1:0] w);
    exp_t e;
    int   t;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout got=0 expected=1 (cyc %0d)", cyc);
    end else begin
      neuron   = n;
      weight   = w;
      in_valid = 1'b1;
      e.res = ref_mult(n, w);
      e.e0  = cyc + 1;
      e.lat = ref_lat(w);
      sbq.push_back(e);
      sent++;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sbq.size() != 0 || out_valid) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (sbq.size() != 0 || out_valid) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d expected=0", sbq.size());
    end
  endtask

  initial begin
    logic [LANES*DW-1:0] n;
    logic [LANES*DW-1:0] w;
    int                  t;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk_vec("rst_mult_result", mult_result, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Ramp neuron, constant weight
    out_ready = 1'b1;
    for (int j = 0; j < LANES; j++) begin
      n[DW*j +: DW] = DW'(j + 1);
      w[DW*j +: DW] = DW'(2);
    end
    send(n, w);
    drain();

    // Extremes
    for (int j = 0; j < LANES; j++) begin
      n[DW*j +: DW] = 16'h8000;
      w[DW*j +: DW] = 16'h8000;
    end
    send(n, w);
    drain();
    for (int j = 0; j < LANES; j++) begin
      n[DW*j +: DW] = 16'hFFFF;
      w[DW*j +: DW] = 16'h7FFF;
    end
    send(n, w);
    drain();

    // Backpressure with ignored in_valid pulses
    out_ready = 1'b0;
    send(rand_vec(), rand_vec());
    t = 0;
    while (!out_valid && t < 50) begin
      in_valid = 1'b1;
      neuron   = rand_vec();
      weight   = rand_vec();
      @(posedge clk); #1;
      t++;
    end
    chk("wait_out_valid", int'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'(i % 2);
      neuron   = rand_vec();
      weight   = rand_vec();
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_out_valid", int'(out_valid), 0);
    chk("release_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    drain();

    // Reset during the second BUSY cycle
    for (int j = 0; j < LANES; j++) w[DW*j +: DW] = DW'(j + 5);
    send(rand_vec(), w);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk_vec("midrst_mult_result", mult_result, '0);
    sbq.delete();
    lost++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(rand_vec(), rand_vec());
    drain();

    // Only the first multiplier group carries nonzero weights
    w = '0;
    for (int j = 0; j < MULS; j++) w[DW*j +: DW] = DW'(3);
    send(rand_vec(), w);
    drain();
    send(rand_vec(), '0);
    drain();

    // Random vectors, random backpressure, some zeroed weight groups
    rand_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w = rand_vec();
      for (int g = 0; g < PASSES; g++) begin
        if ($urandom_range(0, 2) == 0) w[g*MULS*DW +: MULS*DW] = '0;
      end
      send(rand_vec(), w);
    end
    drain();
    rand_ready = 1'b0;

    chk("received_count", recvd, sent - lost);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
